// File: rtl/multiword_add_seq_if.sv
// Request/result bundle for the limb-serial multi-precision adder.
interface multiword_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract: one 32-bit adder stepped over WORDS limbs, LSB limb first,
// with the carry chained through a register between limbs.
module multiword_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus
);
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [WORDS-1:0][31:0] limbs_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    limbs_t             opa_q,   opa_d;
    limbs_t             opb_q,   opb_d;
    limbs_t             acc_q,   acc_d;
    limbs_t             sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;
    logic [32:0]        limb_sum;
    logic               last_limb;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and limb datapath
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        last_limb = (idx_q == IDX_W'(WORDS - 1));
        limb_sum  = {1'b0, opa_q[idx_q]} + {1'b0, opb_q[idx_q]} + 33'(carry_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract folds into the add as a + ~b + 1
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[idx_q] = limb_sum[31:0];
                carry_d      = limb_sum[32];
                idx_d        = idx_q + IDX_W'(1);
                if (last_limb) begin
                    state_d = DONE;
                    idx_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = limb_sum[32];
                    ovf_d   = (opa_q[WORDS-1][31] == opb_q[WORDS-1][31]) &&
                              (limb_sum[31] != opa_q[WORDS-1][31]);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule
